// File: rtl/conv_relu_maxpool.sv
// ReLU plus 2x2 stride-2 max pooling on IEEE-754 single feature rows.
// Two rows are merged into one pooled row, which is then streamed out one word per handshake.
module conv_relu_maxpool #(
  parameter int ARRAY_SIZE   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int FEATURE_ROWS = 6,
  parameter int RELU_EN      = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]     in_feature,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(ARRAY_SIZE/2)-1:0]      out_col,
  output logic [$clog2(FEATURE_ROWS/2)-1:0]    out_row,
  output logic                                 frame_done
);
  localparam int PAIRS     = ARRAY_SIZE / 2;
  localparam int ROW_PAIRS = FEATURE_ROWS / 2;
  localparam int CW        = $clog2(PAIRS);
  localparam int RW        = $clog2(ROW_PAIRS);
  localparam logic [CW-1:0] LAST_COL = CW'(PAIRS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROW_PAIRS - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never drops and data never changes until that transfer.
  typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, SEND} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] lane     [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] hmax     [PAIRS];
  logic [DATA_WIDTH-1:0] pair_buf [PAIRS];
  logic [DATA_WIDTH-1:0] result   [PAIRS];

  // Total-order max over float bit patterns; ties keep the left operand.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    if (RELU_EN != 0)                          r = (b > a) ? b : a;
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) r = a[DATA_WIDTH-1] ? b : a;
    else if (a[DATA_WIDTH-1])                  r = (b < a) ? b : a;
    else                                       r = (b > a) ? b : a;
    return r;
  endfunction

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] raw;
    assign raw     = in_feature[(ARRAY_SIZE-i)*DATA_WIDTH-1 -: DATA_WIDTH];
    assign lane[i] = (RELU_EN != 0 && raw[DATA_WIDTH-1]) ? '0 : raw;
  end

  for (genvar k = 0; k < PAIRS; k++) begin : g_hmax
    assign hmax[k] = fmax(lane[2*k], lane[2*k+1]);
  end

  assign in_ready   = (state != SEND);
  assign out_data   = result[out_col];
  assign frame_done = out_valid & out_ready & (out_col == LAST_COL) & (out_row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ROW_EVEN;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_row   <= '0;
      for (int k = 0; k < PAIRS; k++) begin
        pair_buf[k] <= '0;
        result[k]   <= '0;
      end
    end else begin
      case (state)
        ROW_EVEN: begin
          if (in_valid) begin
            for (int k = 0; k < PAIRS; k++) pair_buf[k] <= hmax[k];
            state <= ROW_ODD;
          end
        end
        ROW_ODD: begin
          if (in_valid) begin
            for (int k = 0; k < PAIRS; k++) result[k] <= fmax(pair_buf[k], hmax[k]);
            out_col   <= '0;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_col != LAST_COL) begin
              out_col <= out_col + 1'b1;
            end else begin
              out_valid <= 1'b0;
              out_row   <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
              state     <= ROW_EVEN;
            end
          end
        end
        default: state <= ROW_EVEN;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_relu_maxpool.sv
// Bench for conv_relu_maxpool: one instance with ReLU, one without, fed identical rows.
// Table-driven row pairs plus backpressure, reset-in-send and full-frame sequences.
module tb_conv_relu_maxpool;
  localparam int AW = 6 * 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] in_feature;
  logic          in_valid;
  logic          out_ready;
  logic          in_ready1, in_ready0;
  logic [31:0]   out_data1, out_data0;
  logic          out_valid1, out_valid0;
  logic [1:0]    out_col1, out_col0, out_row1, out_row0;
  logic          frame_done1, frame_done0;

  conv_relu_maxpool #(.ARRAY_SIZE(6), .DATA_WIDTH(32), .FEATURE_ROWS(6), .RELU_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_feature(in_feature), .in_valid(in_valid),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_col(out_col1), .out_row(out_row1), .frame_done(frame_done1));

  conv_relu_maxpool #(.ARRAY_SIZE(6), .DATA_WIDTH(32), .FEATURE_ROWS(6), .RELU_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_feature(in_feature), .in_valid(in_valid),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_col(out_col0), .out_row(out_row0), .frame_done(frame_done0));

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] r0, r1;
    logic [95:0]   e1, e0;
  } vec_t;
  vec_t vecs[4];

  typedef struct {
    logic [31:0] d1, d0;
    logic [1:0]  col, row;
    logic        fd;
  } exp_t;
  exp_t exp_q[$];

  int          total = 0;
  int          bad   = 0;
  logic [1:0]  exp_row = 2'd0;
  logic        rand_rdy = 1'b0;
  logic [1:0]  bp_row;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] word(logic [95:0] e, int k);
    return e[(2-k)*32 +: 32];
  endfunction

  function automatic logic [AW-1:0] frow(int r);
    logic [AW-1:0] v;
    for (int l = 0; l < 6; l++) v[(5-l)*32 +: 32] = 32'h3F80_0000 + 32'(r*6 + l);
    return v;
  endfunction

  task automatic push_word(logic [31:0] d1, logic [31:0] d0, logic [1:0] col, logic fd);
    exp_t e;
    e.d1 = d1; e.d0 = d0; e.col = col; e.row = exp_row; e.fd = fd;
    exp_q.push_back(e);
  endtask

  task automatic push_pair(logic [95:0] e1, logic [95:0] e0);
    for (int k = 0; k < 3; k++)
      push_word(word(e1, k), word(e0, k), 2'(k), (exp_row == 2'd2) && (k == 2));
    exp_row = (exp_row == 2'd2) ? 2'd0 : exp_row + 2'd1;
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic send_row(logic [AW-1:0] r);
    int n = 0;
    in_feature = r;
    in_valid   = 1'b1;
    while (!in_ready1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'b0, in_ready1}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  always @(negedge clk) if (rand_rdy) out_ready = 1'($urandom_range(0, 1));

  // Scoreboard: sampled between the falling and rising edge, so inputs are settled.
  logic hs, efd;
  exp_t cur;
  always begin
    @(negedge clk);
    #3;
    if (rst_n === 1'b1) begin
      hs  = out_valid1 && out_ready;
      efd = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h want none at %0t", out_data1, $time);
        end else begin
          cur = exp_q.pop_front();
          efd = cur.fd;
          chk("data_relu", out_data1, cur.d1);
          chk("data_raw", out_data0, cur.d0);
          chk("col_relu", {30'b0, out_col1}, {30'b0, cur.col});
          chk("row_relu", {30'b0, out_row1}, {30'b0, cur.row});
          chk("col_raw", {30'b0, out_col0}, {30'b0, cur.col});
          chk("row_raw", {30'b0, out_row0}, {30'b0, cur.row});
          chk("valid_raw", {31'b0, out_valid0}, 32'd1);
        end
      end
      chk("frame_done_relu", {31'b0, frame_done1}, {31'b0, efd});
      chk("frame_done_raw", {31'b0, frame_done0}, {31'b0, efd});
    end
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_feature = '0; out_ready = 1'b1;

    vecs[0].r0 = {32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000, 32'h40800000, 32'h3F000000};
    vecs[0].r1 = {32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F800000, 32'hC0800000, 32'h40000000};
    vecs[0].e1 = {32'h40000000, 32'h3F800000, 32'h40800000};
    vecs[0].e0 = {32'h40000000, 32'h3F800000, 32'h40800000};
    vecs[1].r0 = {6{32'hC0400000}};
    vecs[1].r1 = {6{32'hC0400000}};
    vecs[1].e1 = {3{32'h00000000}};
    vecs[1].e0 = {3{32'hC0400000}};
    vecs[2].r0 = {32'hBF800000, 32'hC0400000, 32'h80000000, 32'h00000000, 32'hC0400000, 32'hBF800000};
    vecs[2].r1 = {32'hC0400000, 32'hC0400000, 32'h80000000, 32'h80000000, 32'hC0800000, 32'hC0800000};
    vecs[2].e1 = {3{32'h00000000}};
    vecs[2].e0 = {32'hBF800000, 32'h00000000, 32'hBF800000};
    vecs[3].r0 = {32'h7FC00000, 32'h3F800000, 32'hFFC00000, 32'h3F800000, 32'h00000001, 32'h00000000};
    vecs[3].r1 = {32'h40000000, 32'h7F800000, 32'h00000000, 32'h00000000, 32'h80000001, 32'h00000002};
    vecs[3].e1 = {32'h7FC00000, 32'h3F800000, 32'h00000002};
    vecs[3].e0 = {32'h7FC00000, 32'h3F800000, 32'h00000002};

    @(negedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready1}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid1}, 32'd0);
    chk("rst_out_data", out_data1, 32'd0);
    chk("rst_col_row", {28'b0, out_col1, out_row1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      push_pair(vecs[i].e1, vecs[i].e0);
      send_row(vecs[i].r0);
      send_row(vecs[i].r1);
      chk("first_word_latency", {31'b0, out_valid1}, 32'd1);
      drain(20);
    end

    // Backpressure on word 1 with the next row waiting upstream.
    bp_row = exp_row;
    push_pair(vecs[0].e1, vecs[0].e0);
    send_row(vecs[0].r0);
    send_row(vecs[0].r1);
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_feature = vecs[1].r0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'b0, in_ready1}, 32'd0);
      chk("bp_valid", {31'b0, out_valid1}, 32'd1);
      chk("bp_data", out_data1, word(vecs[0].e1, 1));
      chk("bp_col", {30'b0, out_col1}, 32'd1);
      chk("bp_row", {30'b0, out_row1}, {30'b0, bp_row});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_w2", {31'b0, in_ready1}, 32'd0);
    push_pair(vecs[1].e1, vecs[1].e0);
    @(negedge clk);
    chk("bp_row_taken", {31'b0, in_ready1}, 32'd1);
    chk("bp_idle_valid", {31'b0, out_valid1}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    send_row(vecs[1].r1);
    drain(20);

    // Asynchronous reset in the middle of a pooled row.
    push_word(word(vecs[2].e1, 0), word(vecs[2].e0, 0), 2'd0, 1'b0);
    send_row(vecs[2].r0);
    send_row(vecs[2].r1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'b0, in_ready1}, 32'd1);
    chk("arst_out_valid", {31'b0, out_valid1}, 32'd0);
    chk("arst_out_data", out_data1, 32'd0);
    chk("arst_frame_done", {31'b0, frame_done1}, 32'd0);
    chk("arst_col_row", {28'b0, out_col1, out_row1}, 32'd0);
    chk("arst_sb_empty", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_row = 2'd0;
    @(negedge clk);
    chk("arst_stays_idle", {31'b0, out_valid1}, 32'd0);

    // Full frame under random backpressure, then a pair that starts a new map.
    rand_rdy = 1'b1;
    for (int p = 0; p < 3; p++) begin
      logic [95:0] e;
      for (int k = 0; k < 3; k++) e[(2-k)*32 +: 32] = 32'h3F80_0000 + 32'((2*p+1)*6 + 2*k + 1);
      push_pair(e, e);
      send_row(frow(2*p));
      send_row(frow(2*p+1));
    end
    push_pair(vecs[3].e1, vecs[3].e0);
    send_row(vecs[3].r0);
    send_row(vecs[3].r1);
    drain(300);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_idle", {31'b0, out_valid1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_relu_maxpool.md
Name: conv_relu_maxpool

Overview:
- Stage directly downstream of the convolution kernel array.
- Consumes one 6-wide row of IEEE-754 single-precision feature values per handshake.
- Applies optional ReLU, then 2x2 stride-2 max pooling.
- Streams the pooled map out one 32-bit word per handshake toward the output interface / feature RAM.

Parameters:
- ARRAY_SIZE, 6: feature values per input row (lanes); must be even.
- DATA_WIDTH, 32 (`DATA_WIDTH): bits per value, IEEE-754 single.
- FEATURE_ROWS, 6: input rows per feature map; must be even.
- RELU_EN, 1: 1 applies ReLU before pooling; 0 pools raw values.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_feature  input  ARRAY_SIZE*DATA_WIDTH  feature row; lane 0 in the MSBs [ARRAY_SIZE*DATA_WIDTH-1 -: DATA_WIDTH].
- in_valid  input  1  in_feature valid.
- in_ready  output  1  block accepts a row this cycle.
- out_data  output  DATA_WIDTH  pooled value.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_col  output  $clog2(ARRAY_SIZE/2)  column index of out_data.
- out_row  output  $clog2(FEATURE_ROWS/2)  row index of out_data.
- frame_done  output  1  one-cycle pulse on the handshake of the last pooled word of a map.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=ROW_EVEN; row and column counters = 0.
  - Pair buffer cleared to 0x00000000.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_col=0, out_row=0, frame_done=0.
- Reset mid-operation discards buffered rows and pending outputs. The next accepted row is row 0 of a new map.
- Row accept: in_valid & in_ready at a rising edge.
- ReLU (RELU_EN=1): lane with sign bit 1 (includes -0.0 and negative NaN) becomes 0x00000000; otherwise unchanged.
- Compare rule:
  - RELU_EN=1: all operands are non-negative, so unsigned compare of the bit patterns is used.
  - RELU_EN=0: total order.
    - Both sign 0: larger bits wins.
    - Mixed signs: sign-0 operand wins.
    - Both sign 1: smaller bits wins.
    - +0 vs -0 yields +0.
  - NaN is not special-cased; it follows the bit-order rule.
  - Ties return the left/upper operand (bit-identical anyway).
- State machine:
  - ROW_EVEN: in_ready=1. On accept, store horizontal maxes max(lane 2k, lane 2k+1) for k=0..ARRAY_SIZE/2-1 in the pair buffer, then go to ROW_ODD.
  - ROW_ODD: in_ready=1. On accept, compute horizontal maxes of the new row, then result[k]=max(buffer[k], new[k]). Latch the results, set out_col=0, out_valid=1 the next cycle, go to SEND.
    - Latency: first pooled word is valid 1 cycle after the odd-row handshake.
  - SEND: in_ready=0.
    - out_data=result[out_col].
    - out_data, out_col and out_row hold stable while out_valid & !out_ready.
    - On out_valid & out_ready: if out_col < ARRAY_SIZE/2-1, increment out_col and present the next word in the next cycle (back-to-back, one word per cycle with out_ready held high).
    - Last column handshake:
      - out_valid=0 the next cycle.
      - If out_row = FEATURE_ROWS/2-1: frame_done pulses in the cycle of that handshake and out_row wraps to 0; otherwise out_row increments.
      - Then go to ROW_EVEN.
- in_valid during SEND is ignored and not lost: the upstream holds the row because in_ready=0.
- No output is produced for ROW_EVEN accepts.
- out_valid never drops without a handshake.
- Throughput: one map row pair per 2 + ARRAY_SIZE/2 cycles minimum.

Test Plan:
- Reset check: assert rst_n=0 asynchronously mid-cycle -> in_ready=1, out_valid=0, out_data=0, frame_done=0 immediately; after release the next row is treated as row 0.
- Basic pool, RELU_EN=1, out_ready=1:
  - Stimulus: row0 = 1.0,2.0,-3.0,0.5,4.0,0.5 (0x3F800000,0x40000000,0xC0400000,0x3F000000,0x40800000,0x3F000000); row1 = 0.5,0.5,0.5,1.0,-4.0,2.0.
  - Response: out_data = 0x40000000, 0x3F800000, 0x40800000 on consecutive cycles, starting 1 cycle after row1's handshake, with out_col 0,1,2 and out_row=0.
- ReLU all-negative: both rows all 0xC0400000 -> three outputs of 0x00000000. With RELU_EN=0, the same rows produce 0xC0400000; -1.0 vs -3.0 yields 0xBF800000; -0.0 vs +0.0 yields 0x00000000.
- Backpressure: out_ready=0 for 5 cycles on word 1 -> out_data, out_col and out_row stable, in_ready=0, and a row presented meanwhile is accepted only after word 2's handshake.
- Full frame: 6 rows with out_ready random -> 9 words total, out_row 0..2; frame_done is a single pulse on the handshake of word (row 2, col 2); a 7th row starts again at out_row=0.
- Reset in SEND after word 0 -> out_valid=0, no further words of that pair; a new row pair then yields correct results at out_row=0.
